// File: rtl/video_frame_source_pkg.sv
// Shared types for the camera-to-Avalon-ST video frame source.
// FSM state encoding, FIFO entry layout and the pad beat used to close frames.
package video_frame_source_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DROP
    } state_t;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    localparam beat_t PAD_BEAT = '{data: 24'h0, sop: 1'b0, eop: 1'b1};

    localparam logic [7:0] PATTERN_TAG = 8'hA5;

endpackage

// File: rtl/video_sync_fifo.sv
// Synchronous FIFO with full/empty flags and same-cycle push/pop.
// Read data is the head entry, valid whenever the FIFO is not empty.
module video_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 26
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (i_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/video_frame_source.sv
// Camera pixel stream to Avalon-ST frame packets with pad-EOP recovery.
// Define VIDEO_FRAME_SOURCE_TEST_PATTERN_EN to add the pattern_en test pattern.
module video_frame_source
    import video_frame_source_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        pix_fv,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
`ifdef VIDEO_FRAME_SOURCE_TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic        stat_clear,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_fv_d;
    logic [15:0] r_x;
    logic [15:0] r_y;
    beat_t       r_out;
    logic        r_valid;
    logic        r_ovf;
    logic [15:0] r_fc;

    logic        w_rise;
    logic        w_first;
    logic        w_last;
    logic [23:0] w_pix_data;
    beat_t       w_pix_beat;
    beat_t       w_wbeat;
    beat_t       w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_can_push;
    logic        w_ovf_set;
    logic        w_adv;
    logic        w_clr;

    assign w_rise  = pix_fv && !r_fv_d;
    assign w_first = (r_x == '0) && (r_y == '0);
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);

`ifdef VIDEO_FRAME_SOURCE_TEST_PATTERN_EN
    assign w_pix_data = pattern_en ? {r_x[7:0], r_y[7:0], PATTERN_TAG}
                                   : pix_data;
`else
    assign w_pix_data = pix_data;
`endif

    assign w_pix_beat = {w_pix_data, w_first, w_last};
    assign w_pop      = (!r_valid || src_ready) && !w_empty;
    assign w_can_push = !w_full || w_pop;

    video_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BEAT_W)
    ) u_fifo (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_push  (w_push),
        .i_wdata (w_wbeat),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_wbeat     = w_pix_beat;
        w_ovf_set   = 1'b0;
        w_adv       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_STREAM;
                    w_clr       = 1'b1;
                end
            end
            S_STREAM: begin
                if (pix_fv && pix_valid) begin
                    if (w_can_push) begin
                        w_push = 1'b1;
                        w_adv  = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_DROP;
                        end
                    end else begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = S_FLUSH;
                    end
                end else if (!pix_fv) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_wbeat     = PAD_BEAT;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!pix_fv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_fv_d resets high so a frame already in progress at reset release is skipped
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_fv_d  <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fv_d  <= pix_fv;
            if (w_clr) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_adv) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_fc    <= '0;
        end else begin
            if (!r_valid || src_ready) begin
                r_valid <= !w_empty;
                if (!w_empty) begin
                    r_out <= w_head;
                end
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (stat_clear) begin
                r_ovf <= 1'b0;
            end
            if (r_valid && src_ready && r_out.eop) begin
                r_fc <= r_fc + 16'd1;
            end
        end
    end

    assign src_data          = r_out.data;
    assign src_startofpacket = r_out.sop;
    assign src_endofpacket   = r_out.eop;
    assign src_valid         = r_valid;
    assign overflow          = r_ovf;
    assign frame_count       = r_fc;

endmodule

// File: tb/tb_video_frame_source.sv
// Self-checking bench for video_frame_source (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4).
// Frame-level reference model builds the expected beat queue from framing rules.
module tb_video_frame_source;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_fv = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        src_ready = 1'b0;
    logic        pat_en = 1'b0;
    logic        stat_clear = 1'b0;
    logic [23:0] src_data;
    logic        src_sop;
    logic        src_eop;
    logic        src_valid;
    logic        overflow;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;
    int beats = 0;
    int rmode = 1;
    int exp_fc = 0;
    logic exp_ovf = 1'b0;
    logic [25:0] expq[$];
    logic [23:0] rx[16];

    typedef struct {
        int npix;
        int gapmax;
        int rmode;
        bit ovf;
        int clr_idx;
        bit clr_before;
        int exp_beats;
        bit lat;
    } row_t;

    row_t rows[10];

    video_frame_source #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .pix_fv            (pix_fv),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .src_data          (src_data),
        .src_startofpacket (src_sop),
        .src_endofpacket   (src_eop),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
`ifdef VIDEO_FRAME_SOURCE_TEST_PATTERN_EN
        .pattern_en        (pat_en),
`endif
        .stat_clear        (stat_clear),
        .overflow          (overflow),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_data(input int i,
                                               input logic [23:0] d);
        logic [23:0] r;
        r = d;
`ifdef VIDEO_FRAME_SOURCE_TEST_PATTERN_EN
        if (pat_en) r = {8'(i % W), 8'(i / W), 8'hA5};
`endif
        return r;
    endfunction

    // sink ready: never two stalled cycles in a row in random mode
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: src_ready = 1'b0;
            1: src_ready = 1'b1;
            2: src_ready = ~src_ready;
            default: src_ready = src_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        endcase
    end

    logic        p_stall = 1'b0;
    logic [25:0] p_beat = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall)
                chk("hold", {src_valid, src_data, src_sop, src_eop},
                    {1'b1, p_beat});
            if (src_valid && src_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat act=%h exp=none",
                             {src_data, src_sop, src_eop});
                end else begin
                    chk("beat", {src_data, src_sop, src_eop}, expq.pop_front());
                end
                if (beats < 16) rx[beats] = src_data;
                beats++;
            end
            p_stall = src_valid && !src_ready;
            p_beat  = {src_data, src_sop, src_eop};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int npix, input int gapmax, input bit ovf,
                               input int clr_idx, input bit lat);
        int acc;
        int got;
        logic [23:0] d;
        logic [23:0] d0;
        acc = ovf ? D + 1 : N;
        got = 0;
        d0 = '0;
        step();
        pix_fv = 1'b1;
        step();
        for (int i = 0; i < npix; i++) begin
            d = 24'($urandom);
            if (i == 0) d0 = d;
            pix_valid  = 1'b1;
            pix_data   = d;
            stat_clear = (i == clr_idx);
            if (i < acc) begin
                expq.push_back({model_data(i, d), 1'(i == 0), 1'(i == N - 1)});
                got++;
            end
            step();
            pix_valid  = 1'b0;
            stat_clear = 1'b0;
            if (lat && i == 0) chk("latency_1", {31'd0, src_valid}, 0);
            if (lat && i == 1)
                chk("latency_2", {src_valid, src_data}, {1'b1, model_data(0, d0)});
            if (gapmax > 0) repeat ($urandom_range(1, gapmax)) step();
        end
        if (got < N) expq.push_back({24'h0, 1'b0, 1'b1});
        pix_fv = 1'b0;
        repeat (3) step();
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && expq.size() != 0; c++) @(posedge clk);
        repeat (2) step();
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout act=%0d exp=0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rows[0] = '{8, 0, 1, 1'b0, -1, 1'b0, 8, 1'b1};
        rows[1] = '{8, 1, 2, 1'b0, -1, 1'b0, 8, 1'b0};
        rows[2] = '{5, 0, 1, 1'b0, -1, 1'b0, 6, 1'b0};
        rows[3] = '{0, 0, 1, 1'b0, -1, 1'b0, 1, 1'b0};
        for (int r = 4; r < 8; r++) begin
            n = $urandom_range(0, N);
            rows[r] = '{n, 3, 3, 1'b0, -1, 1'b0, (n == N) ? N : n + 1, 1'b0};
        end
        rows[8] = '{8, 0, 0, 1'b1, -1, 1'b0, D + 2, 1'b0};
        rows[9] = '{8, 0, 0, 1'b1, 5, 1'b1, D + 2, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, src_valid}, 0);
        chk("rst_data", {8'd0, src_data}, 0);
        chk("rst_sop_eop", {30'd0, src_sop, src_eop}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_frame_count", {16'd0, frame_count}, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        for (int r = 0; r < 10; r++) begin
            if (rows[r].clr_before) begin
                stat_clear = 1'b1;
                step();
                stat_clear = 1'b0;
                exp_ovf = 1'b0;
                chk("ovf_clear", {31'd0, overflow}, {31'd0, exp_ovf});
            end
            rmode = rows[r].rmode;
            step();
            beats = 0;
            drive_frame(rows[r].npix, rows[r].gapmax, rows[r].ovf,
                        rows[r].clr_idx, rows[r].lat);
            if (rows[r].ovf) begin
                exp_ovf = 1'b1;
                chk("ovf_set", {31'd0, overflow}, 1);
                rmode = 1;
            end
            drain();
            exp_fc++;
            chk("beats", beats, rows[r].exp_beats);
            chk("frame_count", {16'd0, frame_count}, exp_fc);
            chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        end

        // reset asserted at pixel 3 with pix_fv held high
        rmode = 1;
        step();
        pix_fv = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            pix_data  = 24'($urandom);
            expq.push_back({pix_data, 1'(i == 0), 1'b0});
            step();
        end
        rst_n = 1'b0;
        expq.delete();
        exp_fc = 0;
        exp_ovf = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst2_valid", {31'd0, src_valid}, 0);
        chk("rst2_frame_count", {16'd0, frame_count}, 0);
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            pix_valid = i[0];
            pix_data  = 24'($urandom);
            step();
        end
        pix_valid = 1'b0;
        chk("no_out_after_rst", beats, 0);
        pix_fv = 1'b0;
        repeat (3) step();
        beats = 0;
        drive_frame(N, 0, 1'b0, -1, 1'b0);
        drain();
        exp_fc++;
        chk("rst2_beats", beats, N);
        chk("rst2_frame_count2", {16'd0, frame_count}, exp_fc);

`ifdef VIDEO_FRAME_SOURCE_TEST_PATTERN_EN
        pat_en = 1'b1;
        beats = 0;
        drive_frame(N, 0, 1'b0, -1, 1'b0);
        drain();
        exp_fc++;
        chk("pattern_beat5", {8'd0, rx[5]}, 32'h0001_01A5);
        chk("pattern_frame_count", {16'd0, frame_count}, exp_fc);
        pat_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
